// File: rtl/sprite_scroll_addr_gen.sv
// Per-pixel ROM address and hit flag for one vertically scrolling sprite on a 640x480 raster.
// Optional horizontal flip is built when SPRITE_MIRROR_EN is defined.
module sprite_scroll_addr_gen #(
   parameter int unsigned H_RES  = 640,
   parameter int unsigned V_RES  = 480,
   parameter int unsigned SPR_W  = 50,
   parameter int unsigned SPR_H  = 50,
   parameter int unsigned X0     = 295,
   parameter int unsigned Y_INIT = 0,
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        h_cnt,
   input  logic [9:0]        v_cnt,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic              bounce,
   input  logic [3:0]        speed,
   input  logic              mirror,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic              in_sprite,
   output logic [9:0]        pos_y,
   output logic [1:0]        state
);

   localparam logic [10:0] L_HRES  = 11'(H_RES);
   localparam logic [10:0] L_VRES  = 11'(V_RES);
   localparam logic [10:0] L_SPRW  = 11'(SPR_W);
   localparam logic [10:0] L_SPRH  = 11'(SPR_H);
   localparam logic [10:0] L_X0    = 11'(X0);
   localparam logic [10:0] L_BOT   = 11'(V_RES - SPR_H);
   localparam logic [9:0]  L_YINIT = 10'(Y_INIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [9:0]        r_pos_y;
   logic              r_dir_up;
   logic [9:0]        w_pos_nxt;
   logic              w_dir_nxt;
   logic              r_v_prev;
   logic              r_frame_tick;
   logic              w_v_end;
   logic [10:0]       w_sum;
   logic [10:0]       w_h;
   logic [10:0]       w_v;
   logic [10:0]       w_p;
   logic [10:0]       w_pend;
   logic              w_hx;
   logic              w_hy;
   logic              w_vis;
   logic              w_hit;
   logic [10:0]       w_rx;
   logic [10:0]       w_ry;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] r_pixel_addr;
   logic              r_in_sprite;

   // Frame tick: rising edge of v_cnt==V_RES against the previous-cycle compare.
   assign w_v_end = ({1'b0, v_cnt} == L_VRES);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v_prev     <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_v_prev     <= w_v_end;
         r_frame_tick <= w_v_end & ~r_v_prev;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_pos_y  <= L_YINIT;
         r_dir_up <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pos_y  <= w_pos_nxt;
         r_dir_up <= w_dir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (stop) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (pause)  w_state_nxt = ST_HOLD;
            ST_HOLD: if (!pause) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_sum     = {1'b0, r_pos_y} + {7'b0, speed};
      w_pos_nxt = r_pos_y;
      w_dir_nxt = r_dir_up;
      if (stop) begin
         w_pos_nxt = L_YINIT;
         w_dir_nxt = 1'b0;
      end else if (r_state == ST_RUN && r_frame_tick && speed != 4'd0) begin
         if (!bounce) begin
            w_pos_nxt = (w_sum >= L_VRES) ? 10'(w_sum - L_VRES) : w_sum[9:0];
         end else if (!r_dir_up) begin
            if (w_sum >= L_BOT) begin
               w_pos_nxt = L_BOT[9:0];
               w_dir_nxt = 1'b1;
            end else begin
               w_pos_nxt = w_sum[9:0];
            end
         end else begin
            if ({1'b0, r_pos_y} <= {7'b0, speed}) begin
               w_pos_nxt = '0;
               w_dir_nxt = 1'b0;
            end else begin
               w_pos_nxt = r_pos_y - {6'b0, speed};
            end
         end
      end
   end

   // Wrap mode lets the sprite straddle the bottom edge; the overflow rows reappear at the top.
   always_comb begin
      w_h    = {1'b0, h_cnt};
      w_v    = {1'b0, v_cnt};
      w_p    = {1'b0, r_pos_y};
      w_pend = w_p + L_SPRH;
      w_hx   = (w_h >= L_X0) && (w_h < L_X0 + L_SPRW);
      w_hy   = ((w_v >= w_p) && (w_v < w_pend)) ||
               (!bounce && (w_pend > L_VRES) && (w_v < w_pend - L_VRES));
      w_vis  = (w_h < L_HRES) && (w_v < L_VRES);
      w_hit  = w_hx && w_hy && w_vis;
      w_ry   = (w_v >= w_p) ? (w_v - w_p) : (w_v + L_VRES - w_p);
      w_rx   = w_h - L_X0;
`ifdef SPRITE_MIRROR_EN
      if (mirror) w_rx = L_SPRW - 11'd1 - w_rx;
`endif
      w_addr = ADDR_W'(w_ry) * ADDR_W'(SPR_W) + ADDR_W'(w_rx);
   end

`ifndef SPRITE_MIRROR_EN
   logic w_unused_mirror;
   assign w_unused_mirror = mirror;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_in_sprite  <= 1'b0;
         r_pixel_addr <= '0;
      end else begin
         r_in_sprite  <= w_hit;
         r_pixel_addr <= w_hit ? w_addr : '0;
      end
   end

   assign pixel_addr = r_pixel_addr;
   assign in_sprite  = r_in_sprite;
   assign pos_y      = r_pos_y;
   assign state      = r_state;

endmodule

// File: tb/tb_sprite_scroll_addr_gen.sv
// Randomized bench for sprite_scroll_addr_gen against a frame-level reference model.
// Honours SPRITE_MIRROR_EN the same way as the design.
module tb_sprite_scroll_addr_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  h_cnt = 10'd300;
   logic [9:0]  v_cnt = 10'd10;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        stop = 1'b0;
   logic        bounce = 1'b0;
   logic [3:0]  speed = 4'd0;
   logic        mirror = 1'b0;
   logic [16:0] pixel_addr;
   logic        in_sprite;
   logic [9:0]  pos_y;
   logic [1:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: 0 idle, 1 run, 2 hold
   int m_state = 0;
   int m_pos   = 0;
   bit m_up    = 1'b0;

   always #5 clk = ~clk;

   sprite_scroll_addr_gen #(
      .H_RES(640), .V_RES(480), .SPR_W(50), .SPR_H(50),
      .X0(295), .Y_INIT(0), .ADDR_W(17)
   ) u_dut (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .start(start), .pause(pause), .stop(stop), .bounce(bounce),
      .speed(speed), .mirror(mirror), .pixel_addr(pixel_addr),
      .in_sprite(in_sprite), .pos_y(pos_y), .state(state)
   );

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      int ns = m_state;
      if (stop) begin
         ns = 0; m_pos = 0; m_up = 1'b0;
      end else if (m_state == 0 && start) ns = 1;
      else if (m_state == 1 && pause)     ns = 2;
      else if (m_state == 2 && !pause)    ns = 1;
      @(posedge clk); #1;
      m_state = ns;
   endtask

   function automatic void m_step(int s, bit bnc);
      if (s == 0) return;
      if (!bnc) m_pos = (m_pos + s) % 480;
      else if (!m_up) begin
         if (m_pos + s >= 430) begin m_pos = 430; m_up = 1'b1; end
         else m_pos = m_pos + s;
      end else begin
         if (m_pos <= s) begin m_pos = 0; m_up = 1'b0; end
         else m_pos = m_pos - s;
      end
   endfunction

   task automatic do_frame();
      bit run = (m_state == 1);
      h_cnt = 10'd0;
      v_cnt = 10'd480;
      repeat (3) tick();
      v_cnt = 10'd0;
      tick();
      if (run) m_step(int'(speed), bounce);
   endtask

   task automatic check_pix(input int h, input int v);
      int ry, rx, hit, addr;
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      tick();
      ry  = (v - m_pos + 480) % 480;
      rx  = h - 295;
`ifdef SPRITE_MIRROR_EN
      if (mirror) rx = 49 - rx;
`endif
      hit = (h >= 295 && h < 345 && h < 640 && v < 480 && ry < 50 && (!bounce || v >= m_pos)) ? 1 : 0;
      addr = hit ? ry * 50 + rx : 0;
      check("in_sprite", 32'(in_sprite), hit);
      check("pixel_addr", 32'(pixel_addr), addr);
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0; tick();
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0; tick();
   endtask

   initial begin
      int h, v, op;
      // Reset state while the raster points inside the sprite
      repeat (3) @(posedge clk);
      #1;
      check("rst_pos", 32'(pos_y), 0);
      check("rst_in", 32'(in_sprite), 0);
      check("rst_addr", 32'(pixel_addr), 0);
      check("rst_state", 32'(state), 0);
      rst = 1'b1;
      tick();
      check("idle_state", 32'(state), 0);
      tick();
      check("t1_in", 32'(in_sprite), 1);
      check("t1_addr", 32'(pixel_addr), 505);

      // Wrap mode, 40 frames at speed 12
      speed = 4'd12; bounce = 1'b0;
      pulse_start();
      check("run_state", 32'(state), 1);
      for (int k = 1; k <= 40; k++) begin
         do_frame();
         check("wrap_pos", 32'(pos_y), (12 * k) % 480);
         check("wrap_model", 32'(pos_y), m_pos);
      end
      for (int k = 1; k <= 39; k++) do_frame();
      check("wrap_468", 32'(pos_y), 468);
      check_pix(295, 5);
      check("split_addr", 32'(pixel_addr), 850);
      check_pix(295, 40);
      check("split_out", 32'(in_sprite), 0);
      check_pix(300, 470);

      // Bounce from 420 down to the clamp, then back up to the top
      pulse_stop();
      check("stop_pos", 32'(pos_y), 0);
      pulse_start();
      for (int k = 1; k <= 35; k++) do_frame();
      check("pre_bounce", 32'(pos_y), 420);
      bounce = 1'b1;
      do_frame();
      check("bounce_clamp", 32'(pos_y), 430);
      do_frame();
      check("bounce_up", 32'(pos_y), 418);
      for (int k = 1; k <= 34; k++) begin
         do_frame();
         check("bounce_model", 32'(pos_y), m_pos);
      end
      check("bounce_10", 32'(pos_y), 10);
      do_frame();
      check("bounce_top", 32'(pos_y), 0);
      do_frame();
      check("bounce_down", 32'(pos_y), 12);

      // Hold freezes motion; stop beats start
      pause = 1'b1;
      tick();
      check("hold_state", 32'(state), 2);
      repeat (3) do_frame();
      check("hold_pos", 32'(pos_y), 12);
      check("hold_state2", 32'(state), 2);
      stop = 1'b1; start = 1'b1;
      tick();
      stop = 1'b0; start = 1'b0;
      check("stop_start_state", 32'(state), 0);
      check("stop_start_pos", 32'(pos_y), 0);
      pause = 1'b0;
      tick();

      // Mirror
      mirror = 1'b1; bounce = 1'b0;
      check_pix(295, 0);
`ifdef SPRITE_MIRROR_EN
      check("mirror_addr", 32'(pixel_addr), 49);
`else
      check("mirror_addr", 32'(pixel_addr), 0);
`endif
      mirror = 1'b0;

      // Randomized mix of frames, pixel probes and control changes
      pulse_start();
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 9);
         if (op <= 4) begin
            mirror = 1'($urandom);
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(285, 355);
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023)
                                            : (m_pos + $urandom_range(0, 70) + 470) % 480;
            if (v == 480) v = 481;
            check_pix(h, v);
         end else if (op <= 7) begin
            speed  = 4'($urandom_range(0, 15));
            bounce = 1'($urandom);
            do_frame();
            check("rand_pos", 32'(pos_y), m_pos);
         end else if (op == 8) begin
            pause = 1'($urandom);
            tick();
            check("rand_state", 32'(state), m_state);
         end else begin
            if ($urandom_range(0, 3) == 0) pulse_stop();
            else pulse_start();
            check("rand_ctrl", 32'(state), m_state);
            check("rand_ctrl_pos", 32'(pos_y), m_pos);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
